// File: rtl/pipeline_skid_reg_if.sv
// Handshake bundle for one elastic pipeline stage: upstream side, downstream
// side, stall/squash controls and the occupancy status.
interface pipeline_skid_reg_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic             freeze;
  logic [1:0]       occupancy;

  // Driver of the stage (upstream producer, downstream consumer, hazard unit)
  modport master (
    output in_valid, in_data, out_ready, flush, freeze,
    input  in_ready, out_valid, out_data, occupancy
  );

  // The stage register itself
  modport slave (
    input  in_valid, in_data, out_ready, flush, freeze,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipeline_skid_reg.sv
// Elastic pipeline stage register with valid/ready handshake, freeze (stall),
// flush (squash) and an optional skid entry so in_ready is registered.
module pipeline_skid_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter bit               SKID      = 1'b1
) (
  input logic                CLK,
  input logic                nRST,
  pipeline_skid_reg_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic main_valid;
  logic skid_valid;
  logic in_ready;
  logic push;
  logic pop;

  // Handshake gating and head-of-stage outputs derived from the held state
  always_comb begin
    main_valid = (state_q != ST_EMPTY);
    skid_valid = (state_q == ST_TWO);
    if (SKID) begin
      in_ready = ~skid_valid & ~bus.freeze;
    end else begin
      in_ready = ~bus.freeze & (~main_valid | bus.out_ready);
    end
    push = bus.in_valid & in_ready;
    pop  = main_valid & ~bus.freeze & bus.out_ready;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = main_valid & ~bus.freeze;
  assign bus.out_data  = main_valid ? main_q : NOP_VALUE;
  assign bus.occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  // Next-state: flush beats freeze beats normal push/pop traffic
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else if (!bus.freeze) begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_d  = bus.in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_d = bus.in_data;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end else if (push && SKID) begin
            // Head is stalled: park the new entry behind it to keep FIFO order
            skid_d  = bus.in_data;
            state_d = ST_TWO;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and payload registers, asynchronously cleared to the NOP bubble
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: doc/pipeline_skid_reg.md
Name: pipeline_skid_reg

Overview:
Parametrised, elastic pipeline stage register. It replaces the fixed-field, flush-only stage register with a generic WIDTH-bit payload and a valid/ready handshake on both sides. It adds stall (freeze), flush-priority, NOP bubble output, and an optional second (skid) entry, so in_ready can be registered and backpressure does not form a combinational path across stages. One instance sits between each pair of CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
WIDTH, 32, payload width in bits (packed stage bundle).
NOP_VALUE, '0, WIDTH-bit payload driven on out_data when no valid entry is held; also the reset value of every data register.
SKID, 1, 1 = two-entry skid mode (registered in_ready); 0 = single-entry mode (in_ready combinational from out_ready).

Ports:
CLK  input  1  clock, rising-edge.
nRST  input  1  asynchronous active-low reset.
in_valid  input  1  upstream offers in_data.
in_ready  output  1  stage accepts in_data this cycle.
in_data  input  WIDTH  upstream payload.
out_valid  output  1  out_data is a real entry.
out_ready  input  1  downstream consumes out_data this cycle.
out_data  output  WIDTH  head payload, or NOP_VALUE when empty.
flush  input  1  synchronous squash of all held entries.
freeze  input  1  hold all state (hazard-unit stall).
occupancy  output  2  number of held entries (0..2).

Behaviour:
- Internal state: main (valid+data) and skid (valid+data). States: EMPTY (neither valid), ONE (main valid), TWO (main and skid valid; SKID=1 only).
- Handshake definitions:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_data must stay stable while in_valid=1 and in_ready=0. Dropping in_valid before acceptance is legal.
- Outputs:
  - out_valid = main_valid & ~freeze.
  - out_data = main_valid ? main_data : NOP_VALUE. Shown even during freeze.
  - occupancy = main_valid + skid_valid.
- in_ready:
  - SKID=1: ~skid_valid & ~freeze. Registered skid_valid plus the freeze gate; no out_ready term.
  - SKID=0: ~freeze & (~main_valid | out_ready).
- Transitions at the rising edge, in priority order:
  1. flush=1: main_valid and skid_valid go to 0; data registers go to NOP_VALUE. Any concurrent push or pop is discarded. Next state is EMPTY. flush overrides freeze.
  2. freeze=1: no state change. The handshake gating above makes push=pop=0.
  3. EMPTY, push: main ← in_data, next state ONE.
  4. ONE:
     - push & pop: main ← in_data, stays ONE.
     - pop only: next state EMPTY.
     - push only: SKID=1 → skid ← in_data, next state TWO. SKID=0 cannot occur, because in_ready=0.
  5. TWO:
     - pop: main ← skid, skid_valid ← 0, next state ONE.
     - Push is impossible (in_ready=0).
  6. Otherwise hold.
- Ordering: FIFO order is strict; an entry in skid never overtakes main.
- Latency: an accepted entry appears on out_data one cycle after acceptance. Throughput is one entry per cycle in steady state for both SKID values.
- Reset (nRST=0, asynchronous): main_valid=0, skid_valid=0, data=NOP_VALUE, out_valid=0, out_data=NOP_VALUE, occupancy=0. in_ready=1 once CLK runs with freeze=0. Reset mid-transfer drops all entries.
- Assertions (verification):
  - occupancy never exceeds 1 when SKID=0.
  - No push is recorded while in_ready=0.
  - out_data==NOP_VALUE whenever out_valid=0 and freeze=0.

Test Plan:
- Reset, then stream A1..A4 with out_ready=1 → out_data A1..A4 on consecutive cycles, one cycle after each push; occupancy=1 throughout.
- SKID=1: push 0x11, 0x22 with out_ready=0 → occupancy=2, in_ready=0, out_data=0x11. Raise out_ready → 0x11 then 0x22 in order; in_ready returns to 1 after the first pop.
- SKID=0, same stimulus → occupancy never exceeds 1. in_ready=0 while holding with out_ready=0. in_ready=1 combinationally when out_ready=1.
- freeze=1 for 3 cycles while ONE with in_valid=1 → out_valid=0, in_ready=0, out_data held, no entry lost or duplicated after release.
- flush asserted in TWO together with freeze=1 and in_valid=1 → next cycle occupancy=0, out_data=NOP_VALUE; the pending input is not captured.
- nRST pulsed low asynchronously (between edges) while occupancy=2 → outputs reach reset values immediately; first post-reset push appears after one cycle.
